hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 32, the number of architectural registers; register 0 is hardwired zero.
REQ-002 The block SHALL have parameter LD_LAT, default 2, the cycles from load issue until its result is forwardable.
REQ-003 The block SHALL have parameter MUL_LAT, default 3, the cycles from MUL/MULHU issue until its result is forwardable.
REQ-004 The block SHALL have parameter MUL_PIPELINED, default 1; 0 means the multiplier accepts one operation per MUL_LAT cycles.
REQ-005 The block SHALL have port clk  in  1  system clock, single clock domain, rising edge.
REQ-006 The block SHALL have port rst  in  1  reset, asynchronous and active-low (asserted at 0).
REQ-007 The block SHALL have port issue_valid  in  1  ID holds a valid decoded instruction.
REQ-008 The block SHALL have port issue_class  in  2  instruction class: ALU, LOAD or MUL.
REQ-009 The block SHALL have port issue_reg_wr  in  1  instruction writes rd.
REQ-010 The block SHALL have port issue_rd  in  $clog2(NUM_REGS)  destination index.
REQ-011 The block SHALL have ports rs1, rs2  in  $clog2(NUM_REGS) each  source indices.
REQ-012 The block SHALL have ports rs1_used, rs2_used  in  1 each  source actually read.
REQ-013 The block SHALL have port flush  in  1  kill the instruction in ID this cycle.
REQ-014 The block SHALL have port stall  out  1  hold IF/ID and insert a bubble into ID/EX.
REQ-015 The block SHALL have port busy_vec  out  NUM_REGS  bit i set while register i is pending.
REQ-016 The block SHALL have port pending_cnt  out  $clog2(NUM_REGS)+1  number of pending registers.

Function
REQ-017 The block SHALL keep one countdown counter per register 1..NUM_REGS-1, sized to hold max(LD_LAT, MUL_LAT); register 0 SHALL never be pending.
REQ-018 Accept SHALL be defined as issue_valid & ~flush & ~stall.
REQ-019 On accept with issue_reg_wr=1 and issue_rd!=0, counter[issue_rd] SHALL load 0 for ALU, LD_LAT-1 for LOAD and MUL_LAT-1 for MUL at the next edge.
REQ-020 Every nonzero counter that is not being loaded SHALL decrement by 1 per cycle and saturate at 0.
REQ-021 RAW: stall SHALL be 1 when, for a source x in {rs1, rs2}, x_used=1, x!=0 and counter[x]!=0.
REQ-022 WAW: stall SHALL be 1 when issue_reg_wr=1, issue_rd!=0 and counter[issue_rd]!=0.
REQ-023 Structural: when MUL_PIPELINED=0, stall SHALL be 1 for a MUL issue while the internal mul_busy counter is nonzero; an accepted MUL SHALL load mul_busy with MUL_LAT-1.
REQ-024 stall SHALL be combinational from registered state and current inputs, and SHALL be 0 when issue_valid=0 or flush=1.
REQ-025 flush SHALL NOT clear existing counters, because older instructions still complete.
REQ-026 There SHALL be no same-cycle bypass of an issue into its own stall check; the update becomes visible the following cycle.
REQ-027 busy_vec[i] SHALL be counter[i]!=0, and pending_cnt SHALL be the popcount of busy_vec; both SHALL be registered-state views.
REQ-028 An unknown issue_class encoding SHALL be treated as ALU.

Reset
REQ-029 While rst=0, all counters, mul_busy, busy_vec and pending_cnt SHALL be 0 and stall SHALL be 0, asynchronously.
REQ-030 Reset mid-countdown SHALL discard all pending state, and the first post-reset cycle SHALL see an empty scoreboard.

Structure
REQ-031 A shared package SHALL hold the issue_class enum (CLS_ALU=0, CLS_LOAD=1, CLS_MUL=2) and the default latency constants.
REQ-032 A per-register sub-module sb_entry (counter, load and decrement logic, busy flag) SHALL be instantiated by generate for indices 1..NUM_REGS-1.

Verification
REQ-033 The bench SHALL cover: LOAD to x5 accepted, next instruction reads rs1=x5 -> stall=1 for exactly 1 cycle (LD_LAT=2), then released.
REQ-034 The bench SHALL cover: MUL to x7, then ADD reading rs2=x7 -> stall=1 for 2 cycles (MUL_LAT=3), and busy_vec[7] clears on the third cycle.
REQ-035 The bench SHALL cover: MUL_PIPELINED=0 with back-to-back MULs to x3 and x4 -> second MUL stalled 2 cycles, and pending_cnt never exceeds 1.
REQ-036 The bench SHALL cover: LOAD to x0, then a read of x0 -> no stall, and busy_vec stays 0.
REQ-037 The bench SHALL cover: LOAD to x9 with flush=1 in the issue cycle -> busy_vec[9] stays 0; and LOAD to x9 accepted, then flush -> x9 still counts down.
REQ-038 The bench SHALL cover: rst driven to 0 with x2, x3 pending -> busy_vec=0 and pending_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: issue classes, default latencies and a latency helper.
package hazard_scoreboard_pkg;
  typedef enum logic [1:0] {CLS_ALU = 2'd0, CLS_LOAD = 2'd1, CLS_MUL = 2'd2} issue_class_t;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_LD_LAT = 2;
  localparam int DEF_MUL_LAT = 3;
  function automatic int max_lat(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// sb_entry: per-register countdown until the pending result is forwardable.
module sb_entry import hazard_scoreboard_pkg::*; #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          busy
);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - CW'(1);
  assign busy = cnt != '0;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW/WAW/structural stall generation from per-register countdowns.
module hazard_scoreboard import hazard_scoreboard_pkg::*; #(
  parameter int NUM_REGS      = DEF_NUM_REGS,
  parameter int LD_LAT        = DEF_LD_LAT,
  parameter int MUL_LAT       = DEF_MUL_LAT,
  parameter int MUL_PIPELINED = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  input  logic [1:0]                  issue_class,
  input  logic                        issue_reg_wr,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
  input  logic [$clog2(NUM_REGS)-1:0] rs1,
  input  logic [$clog2(NUM_REGS)-1:0] rs2,
  input  logic                        rs1_used,
  input  logic                        rs2_used,
  input  logic                        flush,
  output logic                        stall,
  output logic [NUM_REGS-1:0]         busy_vec,
  output logic [$clog2(NUM_REGS):0]   pending_cnt
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int PW = RW + 1;
  localparam int CW = $clog2(max_lat(LD_LAT, MUL_LAT) + 1);
  logic accept, is_ld, is_mul, raw, waw, mul_busy;
  logic [CW-1:0] load_val;
  always_comb begin
    is_ld    = issue_class == CLS_LOAD;
    is_mul   = issue_class == CLS_MUL;
    load_val = is_ld ? CW'(LD_LAT - 1) : is_mul ? CW'(MUL_LAT - 1) : '0;
    raw      = (rs1_used && rs1 != '0 && busy_vec[rs1]) || (rs2_used && rs2 != '0 && busy_vec[rs2]);
    waw      = issue_reg_wr && issue_rd != '0 && busy_vec[issue_rd];
    stall    = issue_valid && !flush && (raw || waw || (is_mul && mul_busy));
    accept   = issue_valid && !flush && !stall;
  end
  assign busy_vec[0] = 1'b0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    sb_entry #(.CW(CW)) u_entry (
      .clk      (clk),
      .rst      (rst),
      .load     (accept && issue_reg_wr && issue_rd == RW'(i)),
      .load_val (load_val),
      .busy     (busy_vec[i])
    );
  end
  // An unpipelined multiplier is modelled as one more countdown entry.
  if (MUL_PIPELINED == 0) begin : g_mul_busy
    sb_entry #(.CW(CW)) u_mul (
      .clk      (clk),
      .rst      (rst),
      .load     (accept && is_mul),
      .load_val (CW'(MUL_LAT - 1)),
      .busy     (mul_busy)
    );
  end else begin : g_mul_free
    assign mul_busy = 1'b0;
  end
  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) pending_cnt = pending_cnt + PW'(busy_vec[i]);
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks on a pipelined and an unpipelined-multiplier instance.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic issue_valid = 1'b0, issue_reg_wr = 1'b0, rs1_used = 1'b0, rs2_used = 1'b0, flush = 1'b0;
  logic [1:0] issue_class = 2'd0;
  logic [4:0] issue_rd = '0, rs1 = '0, rs2 = '0;
  logic p_stall, n_stall;
  logic [31:0] p_busy, n_busy;
  logic [5:0] p_cnt, n_cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard u_p (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_class(issue_class),
    .issue_reg_wr(issue_reg_wr), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .flush(flush),
    .stall(p_stall), .busy_vec(p_busy), .pending_cnt(p_cnt)
  );

  hazard_scoreboard #(.LD_LAT(4), .MUL_LAT(3), .MUL_PIPELINED(0)) u_n (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_class(issue_class),
    .issue_reg_wr(issue_reg_wr), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .flush(flush),
    .stall(n_stall), .busy_vec(n_busy), .pending_cnt(n_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] cls, input logic wr, input logic [4:0] rd,
                       input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub,
                       input logic fl);
    issue_valid = 1'b1; issue_class = cls; issue_reg_wr = wr; issue_rd = rd;
    rs1 = a; rs1_used = ua; rs2 = b; rs2_used = ub; flush = fl;
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_reg_wr = 1'b0; rs1_used = 1'b0; rs2_used = 1'b0; flush = 1'b0;
    #1;
  endtask

  initial begin
    #2;
    issue(2'd0, 1'b1, 5'd1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
    check("reset_stall", p_stall, 0);
    check("reset_busy", p_busy, 0);
    check("reset_cnt", p_cnt, 0);
    idle();
    tick();
    rst = 1'b1;
    // load-use: one stall cycle
    issue(2'd1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("ld_issue_stall", p_stall, 0);
    tick();
    issue(2'd0, 1'b1, 5'd6, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    check("ld_use_stall", p_stall, 1);
    check("ld_busy5", p_busy[5], 1);
    check("ld_cnt", p_cnt, 1);
    tick();
    check("ld_release", p_stall, 0);
    check("ld_busy_clear", p_busy, 0);
    tick();
    idle();
    check("alu_no_pending", p_cnt, 0);
    // mul-use: two stall cycles
    issue(2'd2, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("mul_issue_stall", p_stall, 0);
    tick();
    issue(2'd0, 1'b1, 5'd8, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    check("mul_use_stall1", p_stall, 1);
    tick();
    check("mul_use_stall2", p_stall, 1);
    check("mul_busy7_c2", p_busy[7], 1);
    tick();
    check("mul_release", p_stall, 0);
    check("mul_busy7_c3", p_busy[7], 0);
    tick();
    idle();
    // x0 is never pending
    issue(2'd1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    issue(2'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    check("x0_stall", p_stall, 0);
    check("x0_busy", p_busy, 0);
    tick();
    // class 3 behaves as ALU
    issue(2'd3, 1'b1, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    idle();
    check("cls3_busy10", p_busy[10], 0);
    // WAW
    issue(2'd2, 1'b1, 5'd11, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    issue(2'd1, 1'b1, 5'd11, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("waw_stall", p_stall, 1);
    tick();
    tick();
    idle();
    tick();
    // async reset with x2, x3 pending
    issue(2'd2, 1'b1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    issue(2'd2, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    idle();
    check("pre_rst_cnt", p_cnt, 2);
    rst = 1'b0;
    #1;
    check("arst_busy", p_busy, 0);
    check("arst_cnt", p_cnt, 0);
    check("arst_n_busy", n_busy, 0);
    tick();
    rst = 1'b1;
    issue(2'd0, 1'b1, 5'd2, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    check("post_rst_stall", p_stall, 0);
    check("post_rst_cnt", p_cnt, 0);
    idle();
    tick();
    // unpipelined multiplier: structural stall
    issue(2'd2, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("np_mul1_stall", n_stall, 0);
    tick();
    issue(2'd2, 1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("np_mul2_stall1", n_stall, 1);
    check("np_cnt1", n_cnt, 1);
    tick();
    check("np_mul2_stall2", n_stall, 1);
    check("np_cnt2", n_cnt, 1);
    tick();
    check("np_mul2_go", n_stall, 0);
    check("np_cnt3", n_cnt, 0);
    tick();
    idle();
    check("np_cnt4", n_cnt, 1);
    check("np_busy4", n_busy[4], 1);
    tick();
    tick();
    tick();
    // flush in issue cycle kills the load
    issue(2'd1, 1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    check("flush_issue_stall", p_stall, 0);
    tick();
    idle();
    check("flush_busy9", p_busy[9], 0);
    check("flush_n_busy9", n_busy[9], 0);
    // flush after accept keeps the countdown alive
    issue(2'd1, 1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    issue(2'd0, 1'b1, 5'd12, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1);
    check("flush_raw_stall", p_stall, 0);
    check("flush_n_raw_stall", n_stall, 0);
    check("late_flush_busy9", p_busy[9], 1);
    tick();
    idle();
    check("late_flush_n_busy9_a", n_busy[9], 1);
    tick();
    check("late_flush_n_busy9_b", n_busy[9], 1);
    tick();
    check("late_flush_n_busy9_c", n_busy[9], 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
